ad_bus_master: RTL and testbench

AD_BUS_MASTER -- requirements
Module: ad_bus_master

---
 rtl/ad_bus_pkg.sv | 20 ++
 rtl/ad_bus_master.sv | 154 +++++++++++++++
 tb/tb_ad_bus_master.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ad_bus_pkg.sv
// Shared definitions for the multiplexed address/data bus master:
// state encoding, AD word width and default build constants.
package ad_bus_pkg;

  localparam int AD_W        = 32;
  localparam int BURST_W_DEF = 4;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_EN,
    S_ADDR,
    S_WDATA,
    S_TURN,
    S_RDATA,
    S_RCAP,
    S_END
  } state_t;

endpackage

// File: rtl/ad_bus_master.sv
// Burst master for a shared AD bus: address phase, write/read data beats, turnaround.
// Optional TRdy watchdog enabled by defining AD_BUS_MASTER_TIMEOUT_EN.
module ad_bus_master
  import ad_bus_pkg::*;
#(
  parameter int BURST_W = BURST_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [AD_W-1:0]    req_addr,
  input  logic [BURST_W-1:0] req_len,
  input  logic [AD_W-1:0]    wd_data,
  output logic               wd_ready,
  output logic               rd_valid,
  output logic [AD_W-1:0]    rd_data,
  output logic               done,
  output logic               err,
  output logic               Drive,
  output logic               OK,
  output logic [AD_W-1:0]    ADOut,
  input  logic [AD_W-1:0]    IPad,
  output logic               AddrStb,
  output logic               DataStb,
  input  logic               TRdy
);

  state_t               state, nxt;
  logic                 write_q;
  logic [AD_W-1:0]      addr_q;
  logic [AD_W-1:0]      last_q;
  logic [AD_W-1:0]      ad_mux;
  logic [BURST_W-1:0]   cnt_q;
  logic                 cap_q;
  logic                 ok_q;
  logic                 abort;
  logic                 last_beat;

  assign last_beat = (cnt_q == '0);

  always_comb begin
    nxt       = state;
    req_ready = 1'b0;
    Drive     = 1'b0;
    AddrStb   = 1'b0;
    DataStb   = 1'b0;
    wd_ready  = 1'b0;
    done      = 1'b0;
    ad_mux    = last_q;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) nxt = S_ADDR_EN;
      end
      S_ADDR_EN: begin
        Drive  = 1'b1;
        ad_mux = addr_q;
        nxt    = S_ADDR;
      end
      S_ADDR: begin
        Drive   = 1'b1;
        AddrStb = 1'b1;
        ad_mux  = addr_q;
        nxt     = write_q ? S_WDATA : S_TURN;
      end
      S_WDATA: begin
        Drive   = ~abort;
        DataStb = ~abort;
        ad_mux  = wd_data;
        if (abort) begin
          nxt = S_END;
        end else if (TRdy) begin
          wd_ready = 1'b1;
          if (last_beat) nxt = S_END;
        end
      end
      S_TURN: nxt = S_RDATA;
      S_RDATA: begin
        DataStb = ~abort;
        if (abort) nxt = S_END;
        else if (TRdy && last_beat) nxt = S_RCAP;
      end
      S_RCAP: nxt = S_END;
      S_END: begin
        done = 1'b1;
        nxt  = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Pads keep showing the last driven word whenever the master is not driving
  assign ADOut    = Drive ? ad_mux : last_q;
  assign OK       = ok_q & ~abort;
  assign rd_valid = cap_q;
  assign rd_data  = cap_q ? IPad : '0;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= S_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      cap_q   <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      state <= nxt;
      ok_q  <= 1'b1;
      cap_q <= (state == S_RDATA) && TRdy && !abort;
      if (state == S_IDLE && req_valid) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        cnt_q   <= req_len;
      end else if (DataStb && TRdy) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (Drive) last_q <= ad_mux;
    end
  end

`ifdef AD_BUS_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_q;
  logic            err_q;

  assign abort = ((state == S_WDATA) || (state == S_RDATA)) && (to_q == TO_W'(TIMEOUT));
  assign err   = done & err_q;

  // Counts consecutive DataStb cycles without TRdy; any other cycle restarts it
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (DataStb && !TRdy) to_q <= to_q + 1'b1;
      else                  to_q <= '0;
      if (abort)               err_q <= 1'b1;
      else if (state == S_END) err_q <= 1'b0;
    end
  end
`else
  logic unused_timeout;

  assign abort          = 1'b0;
  assign err            = 1'b0;
  assign unused_timeout = (TIMEOUT > 0);
`endif

endmodule

// File: tb/tb_ad_bus_master.sv
// Directed bench for ad_bus_master: write, gapped read, full burst, reset abort,
// TRdy stall (watchdog or indefinite wait) and back-to-back requests.
module tb_ad_bus_master;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [3:0]  req_len;
  logic [31:0] wd_data;
  logic        wd_ready, rd_valid, done, err, Drive, OK, AddrStb, DataStb, TRdy;
  logic [31:0] rd_data, ADOut, IPad;

  int checks = 0;
  int errors = 0;
  int n_wr, n_done, n_err, n_ds, n_as;

  always #5 Clk = ~Clk;

  ad_bus_master dut (
    .Clk(Clk), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wd_data(wd_data), .wd_ready(wd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .err(err), .Drive(Drive), .OK(OK), .ADOut(ADOut),
    .IPad(IPad), .AddrStb(AddrStb), .DataStb(DataStb), .TRdy(TRdy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic start_req(input logic w, input logic [31:0] a, input logic [3:0] l);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_len   = l;
  endtask

  // Runs n cycles, dropping req_valid after acceptance, tallying output pulses
  task automatic run(input int n);
    n_wr = 0; n_done = 0; n_err = 0; n_ds = 0; n_as = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      req_valid = 1'b0;
      settle();
      if (wd_ready) n_wr++;
      if (done)     n_done++;
      if (err)      n_err++;
      if (DataStb)  n_ds++;
      if (AddrStb)  n_as++;
    end
  endtask

  initial begin
    int ds, okdrop, fall, as2, nas, nd, prev_drive;
    Reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wd_data = '0; IPad = '0; TRdy = 1'b0;

    // Reset state
    #3;
    chk("rst_flags", {24'd0, Drive, OK, AddrStb, DataStb, wd_ready, rd_valid, done, err}, 32'd0);
    chk("rst_adout", ADOut, 32'd0);
    chk("rst_rddata", rd_data, 32'd0);
    #5;
    Reset = 1'b1;
    tick();
    chk("post_rst_ok", OK, 1'b1);
    chk("post_rst_ready", req_ready, 1'b1);

    // Single write 0x1000 / 0xDEADBEEF, TRdy immediate
    start_req(1'b1, 32'h1000, 4'd0);
    wd_data = 32'hDEADBEEF;
    TRdy = 1'b1;
    settle();
    tick(); req_valid = 1'b0; settle();
    chk("w_en_drive", Drive, 1'b1);
    chk("w_en_addrstb", AddrStb, 1'b0);
    chk("w_en_adout", ADOut, 32'h1000);
    chk("w_en_ready", req_ready, 1'b0);
    chk("w_en_wdready", wd_ready, 1'b0);
    tick(); settle();
    chk("w_addrstb", AddrStb, 1'b1);
    chk("w_addr_adout", ADOut, 32'h1000);
    tick(); settle();
    chk("w_datastb", DataStb, 1'b1);
    chk("w_data_adout", ADOut, 32'hDEADBEEF);
    chk("w_wdready", wd_ready, 1'b1);
    tick(); TRdy = 1'b0; wd_data = 32'h0; settle();
    chk("w_done", done, 1'b1);
    chk("w_err", err, 1'b0);
    chk("w_end_drive", Drive, 1'b0);
    chk("w_end_adout_hold", ADOut, 32'hDEADBEEF);
    tick(); settle();
    chk("w_idle_done", done, 1'b0);
    chk("w_idle_ready", req_ready, 1'b1);

    // Read len 3 at 0x2000 with TRdy gaps; stray TRdy in TURN must be ignored
    start_req(1'b0, 32'h2000, 4'd3);
    IPad = 32'hAA;
    tick(); req_valid = 1'b0; settle();
    tick(); settle();
    chk("r_addrstb", AddrStb, 1'b1);
    chk("r_addr_adout", ADOut, 32'h2000);
    tick(); TRdy = 1'b1; settle();
    chk("r_turn_drive", Drive, 1'b0);
    chk("r_turn_datastb", DataStb, 1'b0);
    chk("r_turn_adout", ADOut, 32'h2000);
    tick(); TRdy = 1'b0; settle();
    chk("r_rd0_datastb", DataStb, 1'b1);
    chk("r_rd0_valid", rd_valid, 1'b0);
    tick(); TRdy = 1'b1; settle();
    chk("r_beat1_valid", rd_valid, 1'b0);
    tick(); TRdy = 1'b0; IPad = 32'h11; settle();
    chk("r_d1_valid", rd_valid, 1'b1);
    chk("r_d1_data", rd_data, 32'h11);
    tick(); TRdy = 1'b1; IPad = 32'hAA; settle();
    chk("r_gap_valid", rd_valid, 1'b0);
    tick(); TRdy = 1'b1; IPad = 32'h22; settle();
    chk("r_d2_data", {31'd0, rd_valid} + (rd_data << 1), 32'h45);
    tick(); TRdy = 1'b0; IPad = 32'h33; settle();
    chk("r_d3_valid", rd_valid, 1'b1);
    chk("r_d3_data", rd_data, 32'h33);
    tick(); TRdy = 1'b1; IPad = 32'hAA; settle();
    chk("r_beat4_valid", rd_valid, 1'b0);
    chk("r_beat4_datastb", DataStb, 1'b1);
    tick(); TRdy = 1'b0; IPad = 32'h44; settle();
    chk("r_d4_valid", rd_valid, 1'b1);
    chk("r_d4_data", rd_data, 32'h44);
    chk("r_rcap_datastb", DataStb, 1'b0);
    tick(); IPad = 32'hAA; settle();
    chk("r_done", done, 1'b1);
    chk("r_end_valid", rd_valid, 1'b0);
    tick(); settle();
    chk("r_idle_ready", req_ready, 1'b1);

    // Full 16-beat write burst, TRdy held high throughout
    start_req(1'b1, 32'h4000, 4'd15);
    wd_data = 32'h0000CAFE;
    TRdy = 1'b1;
    run(30);
    chk("burst_wdready", n_wr, 32'd16);
    chk("burst_datastb", n_ds, 32'd16);
    chk("burst_done", n_done, 32'd1);
    chk("burst_addrstb", n_as, 32'd1);
    chk("burst_idle", req_ready, 1'b1);

    // Reset during the second write beat
    start_req(1'b1, 32'h3000, 4'd3);
    wd_data = 32'h0B0B0001;
    tick(); req_valid = 1'b0; settle();
    tick(); settle();
    tick(); settle();
    tick(); settle();
    chk("rst_mid_beat2", {30'd0, DataStb, wd_ready}, 32'd3);
    Reset = 1'b0;
    settle();
    chk("rst_mid_flags", {24'd0, Drive, OK, AddrStb, DataStb, wd_ready, rd_valid, done, err}, 32'd0);
    chk("rst_mid_adout", ADOut, 32'd0);
    tick();
    Reset = 1'b1;
    TRdy = 1'b0;
    settle();
    chk("rst_mid_ready", req_ready, 1'b1);
    run(4);
    chk("rst_mid_nodone", n_done, 32'd0);
    start_req(1'b1, 32'h3004, 4'd0);
    wd_data = 32'h5A5A5A5A;
    TRdy = 1'b1;
    run(6);
    chk("rst_after_wr", n_wr, 32'd1);
    chk("rst_after_done", n_done, 32'd1);

    // TRdy never asserted on a write
    TRdy = 1'b0;
    start_req(1'b1, 32'h5000, 4'd0);
    wd_data = 32'h00005000;
    ds = 0; okdrop = 0;
    for (int i = 0; i < 40 && okdrop == 0; i++) begin
      tick(); req_valid = 1'b0; settle();
      if (DataStb) ds++;
      if (!OK) okdrop = 1;
    end
`ifdef AD_BUS_MASTER_TIMEOUT_EN
    chk("to_ds_count", ds, 32'd16);
    chk("to_ok_drop", okdrop, 32'd1);
    chk("to_drive_drop", Drive, 1'b0);
    tick(); settle();
    chk("to_done_err", {30'd0, done, err}, 32'd3);
    tick(); settle();
    chk("to_idle", req_ready, 1'b1);
`else
    chk("stall_ds_count", ds, 32'd38);
    chk("stall_ok", okdrop, 32'd0);
    chk("stall_datastb", DataStb, 1'b1);
    TRdy = 1'b1;
    settle();
    chk("stall_wdready", wd_ready, 1'b1);
    tick(); TRdy = 1'b0; settle();
    chk("stall_done", done, 1'b1);
    chk("stall_err", err, 1'b0);
    tick(); settle();
`endif

    // Back-to-back writes with req_valid held
    start_req(1'b1, 32'h6000, 4'd0);
    wd_data = 32'h00006000;
    TRdy = 1'b1;
    fall = -1; as2 = -1; nas = 0; nd = 0; prev_drive = 0;
    for (int i = 1; i <= 14; i++) begin
      tick(); settle();
      if (prev_drive == 1 && !Drive && fall < 0) fall = i;
      if (AddrStb) begin
        nas++;
        if (nas == 2) begin
          as2 = i;
          req_valid = 1'b0;
        end
      end
      if (done) nd++;
      prev_drive = Drive ? 1 : 0;
    end
    TRdy = 1'b0;
    chk("b2b_fall_seen", fall > 0, 1'b1);
    chk("b2b_gap", (as2 - fall) >= 2, 1'b1);
    chk("b2b_addrstb", nas, 32'd2);
    chk("b2b_done", nd, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
